// File: rtl/alu_mul_sequencer.sv
// Iterative shift-and-add multiplier that drives the shared ALU with ADDs for up to XLEN cycles.
// Optional MUL_EARLY_EXIT_EN: stop once the remaining multiplier bits are all zero.
`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif

module alu_mul_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_RUN  | one add/shift iteration per cycle, ALU borrowed
  // S_DONE | product valid, done pulse; start accepted here too
  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   product_q, product_d;
  logic              last_iter;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    alu_a     = '0;
    alu_b     = '0;
    last_iter = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          acc_d    = '0;
          mcand_d  = op_a;
          mplier_d = op_b;
          cnt_d    = '0;
          state_d  = S_RUN;
`ifdef MUL_EARLY_EXIT_EN
          if (op_b == '0) begin
            product_d = '0;
            state_d   = S_DONE;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef MUL_EARLY_EXIT_EN
        last_iter = (cnt_q == LAST_CNT) || (mplier_d == '0);
`else
        last_iter = (cnt_q == LAST_CNT);
`endif
        if (last_iter) begin
          product_d = alu_result;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign product     = product_q;
  assign alu_control = `ALU_ADD;

endmodule
